// File: rtl/zeroheti_obi_apb_bridge.sv
// zeroheti_obi_apb_bridge: single-outstanding OBI subordinate bridged to an APB requester with access timeout
module zeroheti_obi_apb_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [AddrWidth-1:0]   obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [DataWidth/8-1:0] obi_be_i,
  input  logic [DataWidth-1:0]   obi_wdata_i,
  output logic                   obi_rvalid_o,
  output logic [DataWidth-1:0]   obi_rdata_o,
  output logic                   obi_err_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  output logic [2:0]             pprot_o,
  input  logic                   pready_i,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pslverr_i
);
  localparam int unsigned StrbW  = DataWidth / 8;
  localparam int unsigned CntW   = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned ToLast = TimeoutCycles == 0 ? 0 : TimeoutCycles - 1;
  localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(StrbW - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [StrbW-1:0]     be_q, be_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 active;
  assign active       = (state_q == SETUP) || (state_q == ACCESS);
  assign obi_gnt_o    = (state_q == IDLE) && obi_req_i;
  assign obi_rvalid_o = state_q == RESP;
  assign obi_rdata_o  = obi_rvalid_o ? rdata_q : '0;
  assign obi_err_o    = obi_rvalid_o && err_q;
  assign paddr_o      = addr_q;
  assign psel_o       = active;
  assign penable_o    = state_q == ACCESS;
  assign pwrite_o     = we_q;
  assign pwdata_o     = we_q ? wdata_q : '0;
  assign pstrb_o      = (active && we_q) ? be_q : '0;
  assign pprot_o      = 3'b000;
  // State and transaction registers; async reset abandons any transfer in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // Next-state: latch request on grant, run SETUP/ACCESS, complete on pready or timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (obi_req_i) begin
        state_d = SETUP;
        addr_d  = obi_addr_i & AddrMask;
        we_d    = obi_we_i;
        be_d    = obi_be_i;
        wdata_d = obi_wdata_i;
        cnt_d   = '0;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready_i) begin
        state_d = RESP;
        rdata_d = we_q ? '0 : prdata_i;
        err_d   = pslverr_i;
      end else if (TimeoutCycles != 0 && cnt_q == CntW'(ToLast)) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/zeroheti_obi_apb_bridge.md
ZEROHETI_OBI_APB_BRIDGE -- requirements
Module: zeroheti_obi_apb_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: OBI/APB address width.
REQ-002 SHALL have parameter DataWidth, default 32: data width; strobe width = DataWidth/8.
REQ-003 SHALL have parameter TimeoutCycles, default 16: maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous active-low reset. Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active low
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  AddrWidth  byte address
- obi_we_i  in  1  write enable
- obi_be_i  in  DataWidth/8  byte enables
- obi_wdata_i  in  DataWidth  write data
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  DataWidth  read data
- obi_err_o  out  1  response error
- paddr_o  out  AddrWidth  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- pwdata_o  out  DataWidth  APB write data
- pstrb_o  out  DataWidth/8  APB strobes
- pprot_o  out  3  APB protection, constant 3'b000
- pready_i  in  1  APB ready
- prdata_i  in  DataWidth  APB read data
- pslverr_i  in  1  APB slave error

Function
REQ-005 SHALL implement an OBI subordinate with one outstanding transaction, bridging to one APB requester using FSM states IDLE, SETUP, ACCESS, RESP.
REQ-006 obi_gnt_o SHALL be combinational: 1 iff state==IDLE and obi_req_i==1; 0 in all other states.
REQ-007 On grant, SHALL register addr (low log2(DataWidth/8) bits forced to 0), we, be, wdata; next state SETUP.
REQ-008 SETUP: psel_o=1, penable_o=0; next state ACCESS unconditionally.
REQ-009 ACCESS: psel_o=1, penable_o=1; paddr_o/pwrite_o/pwdata_o/pstrb_o SHALL remain stable from SETUP until exit from ACCESS.
REQ-010 pstrb_o SHALL equal the registered be on writes and all-zero on reads; pwdata_o SHALL be all-zero on reads.
REQ-011 ACCESS with pready_i=1: SHALL capture rdata (prdata_i on read, 0 on write) and err (pslverr_i); next state RESP.
REQ-012 Timeout: wait counter SHALL clear on SETUP entry and increment per ACCESS cycle with pready_i=0; when TimeoutCycles!=0 and counter reaches TimeoutCycles-1 with pready_i=0, SHALL leave ACCESS to RESP with err=1, rdata=0; psel_o/penable_o SHALL be 0 from the next cycle.
REQ-013 pready_i=1 in the timeout cycle SHALL take priority (normal completion).
REQ-014 RESP: obi_rvalid_o=1 for exactly one cycle with obi_rdata_o/obi_err_o valid; next state IDLE; obi_gnt_o=0 in RESP even if obi_req_i=1.
REQ-015 Latency: grant cycle N, SETUP N+1, ACCESS N+2; pready_i at N+2+k gives rvalid at N+3+k; back-to-back grants at minimum 4-cycle spacing.
REQ-016 obi_rdata_o and obi_err_o SHALL be 0 whenever obi_rvalid_o=0.
REQ-017 psel_o, penable_o, pstrb_o SHALL be 0 in IDLE and RESP; paddr_o/pwrite_o SHALL hold last registered values.

Reset
REQ-018 rst_ni=0 SHALL asynchronously force IDLE, wait counter 0, all registered fields and all outputs 0 (pprot_o 3'b000).
REQ-019 Reset mid-transfer SHALL drop psel_o/penable_o immediately; the abandoned transaction SHALL produce no rvalid after reset release.

Verification
REQ-020 Read: req addr=0x1000_0006, we=0, pready=1 in first ACCESS, prdata=0xDEADBEEF -> gnt cycle 0, paddr=0x1000_0004 psel cycle 1, penable cycle 2, rvalid cycle 3 rdata=0xDEADBEEF err=0.
REQ-021 Write with wait states: we=1, be=4'b0101, wdata=0x12345678, pready low 3 ACCESS cycles -> pstrb=4'b0101, pwdata stable throughout, rvalid 1 cycle after pready, rdata=0, err=0.
REQ-022 Slave error: read, pslverr=1 with pready=1 -> rvalid with err=1, rdata=prdata.
REQ-023 Timeout: TimeoutCycles=4, pready never asserted -> exactly 4 ACCESS cycles, then psel=0 and rvalid with err=1, rdata=0; pready=1 in 4th cycle -> normal completion err=0.
REQ-024 Back-to-back: req held high across two transactions -> second gnt exactly one cycle after first rvalid, no gnt during SETUP/ACCESS/RESP.
REQ-025 Reset in ACCESS: assert rst_ni=0 mid-cycle -> psel/penable 0 without clock edge; no rvalid after release; next request serviced normally.
